// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one 64-bit alu between two requesters
// Revision    : 1.0
// ============================================================================

module alu_arbiter_alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out,
    output logic        illegal
);
    logic        is_sub;
    logic        is_arith;
    logic [63:0] b_eff;
    logic [64:0] sum;

    always_comb begin
        is_sub   = (cntrl == 3'b011);
        is_arith = (cntrl == 3'b010) || is_sub;
        b_eff    = is_sub ? ~b : b;
        // Subtract as a + ~b + 1 so carry_out means "no borrow"
        sum      = {1'b0, a} + {1'b0, b_eff} + {64'd0, is_sub};
        illegal  = 1'b0;
        result   = 64'd0;
        case (cntrl)
            3'b000:         result = b;
            3'b010, 3'b011: result = sum[63:0];
            3'b100:         result = a & b;
            3'b101:         result = a | b;
            3'b110:         result = a ^ b;
            default:        illegal = 1'b1;
        endcase
        negative  = ~illegal & result[63];
        zero      = ~illegal & (result == 64'd0);
        carry_out = is_arith & sum[64];
        overflow  = is_arith & (a[63] == b_eff[63]) & (sum[63] != a[63]);
    end
endmodule

module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic [2:0]       req0_cntrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic [2:0]       req1_cntrl,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [63:0]      resp_result,
    output logic             resp_negative,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             resp_carry_out,
    output logic             resp_err,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [63:0]      op_a_q, op_a_d;
    logic [63:0]      op_b_q, op_b_d;
    logic [2:0]       op_cntrl_q, op_cntrl_d;
    logic             op_id_q, op_id_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [63:0]      resp_result_q, resp_result_d;
    logic             resp_negative_q, resp_negative_d;
    logic             resp_zero_q, resp_zero_d;
    logic             resp_overflow_q, resp_overflow_d;
    logic             resp_carry_out_q, resp_carry_out_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic             grant_id;
    logic             accept;
    logic [63:0]      alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;
    logic             alu_illegal;

    // The alu only ever sees the operand registers, never the request ports
    alu_arbiter_alu u_alu (
        .a         (op_a_q),
        .b         (op_b_q),
        .cntrl     (op_cntrl_q),
        .result    (alu_result),
        .negative  (alu_negative),
        .zero      (alu_zero),
        .overflow  (alu_overflow),
        .carry_out (alu_carry_out),
        .illegal   (alu_illegal)
    );

    always_comb begin
        grant_id   = req1_valid & (~req0_valid | rr_q);
        accept     = (state_q == S_IDLE) & reset_n & (req0_valid | req1_valid);
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;

        state_d          = state_q;
        rr_d             = rr_q;
        op_a_d           = op_a_q;
        op_b_d           = op_b_q;
        op_cntrl_d       = op_cntrl_q;
        op_id_d          = op_id_q;
        cnt_d            = cnt_q;
        resp_valid_d     = resp_valid_q;
        resp_id_d        = resp_id_q;
        resp_result_d    = resp_result_q;
        resp_negative_d  = resp_negative_q;
        resp_zero_d      = resp_zero_q;
        resp_overflow_d  = resp_overflow_q;
        resp_carry_out_d = resp_carry_out_q;
        resp_err_d       = resp_err_q;
        ops_done_d       = ops_done_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_a_d     = grant_id ? req1_a : req0_a;
                    op_b_d     = grant_id ? req1_b : req0_b;
                    op_cntrl_d = grant_id ? req1_cntrl : req0_cntrl;
                    op_id_d    = grant_id;
                    cnt_d      = c_cnt_load;
                    rr_d       = ~grant_id;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_result_d    = alu_result;
                    resp_negative_d  = alu_negative;
                    resp_zero_d      = alu_zero;
                    resp_overflow_d  = alu_overflow;
                    resp_carry_out_d = alu_carry_out;
                    resp_err_d       = alu_illegal;
                    resp_id_d        = op_id_q;
                    resp_valid_d     = 1'b1;
                    state_d          = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    ops_done_d   = ops_done_q + CNT_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            rr_q             <= 1'b0;
            op_a_q           <= 64'd0;
            op_b_q           <= 64'd0;
            op_cntrl_q       <= 3'd0;
            op_id_q          <= 1'b0;
            cnt_q            <= 4'd0;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= 1'b0;
            resp_result_q    <= 64'd0;
            resp_negative_q  <= 1'b0;
            resp_zero_q      <= 1'b0;
            resp_overflow_q  <= 1'b0;
            resp_carry_out_q <= 1'b0;
            resp_err_q       <= 1'b0;
            ops_done_q       <= '0;
        end else begin
            state_q          <= state_d;
            rr_q             <= rr_d;
            op_a_q           <= op_a_d;
            op_b_q           <= op_b_d;
            op_cntrl_q       <= op_cntrl_d;
            op_id_q          <= op_id_d;
            cnt_q            <= cnt_d;
            resp_valid_q     <= resp_valid_d;
            resp_id_q        <= resp_id_d;
            resp_result_q    <= resp_result_d;
            resp_negative_q  <= resp_negative_d;
            resp_zero_q      <= resp_zero_d;
            resp_overflow_q  <= resp_overflow_d;
            resp_carry_out_q <= resp_carry_out_d;
            resp_err_q       <= resp_err_d;
            ops_done_q       <= ops_done_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_negative  = resp_negative_q;
    assign resp_zero      = resp_zero_q;
    assign resp_overflow  = resp_overflow_q;
    assign resp_carry_out = resp_carry_out_q;
    assign resp_err       = resp_err_q;
    assign ops_done       = ops_done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : scoreboard bench for alu_arbiter (EXEC_CYCLES 1 and 4)
// Revision       : 1.0
// ============================================================================

module tb_alu_arbiter;
    localparam int E = 1;

    typedef struct packed {
        logic [63:0] result;
        logic        id;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_cntrl, req1_cntrl;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] resp_result;
    logic        resp_negative, resp_zero, resp_overflow, resp_carry_out, resp_err;
    logic [31:0] ops_done;

    logic        reset_n_4;
    logic        req0_valid_4, req0_ready_4, req1_valid_4, req1_ready_4;
    logic [63:0] req0_a_4, req0_b_4, req1_a_4, req1_b_4;
    logic [2:0]  req0_cntrl_4, req1_cntrl_4;
    logic        resp_valid_4, resp_ready_4, resp_id_4;
    logic [63:0] resp_result_4;
    logic        resp_negative_4, resp_zero_4, resp_overflow_4, resp_carry_out_4, resp_err_4;
    logic [31:0] ops_done_4;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 0;
    bit   busy_m = 0;
    bit   rr_m   = 0;
    int   acc_cyc = 0;
    int   done_m = 0;
    bit   rand_done = 0;
    exp_t sb[$];

    alu_arbiter #(.EXEC_CYCLES(E), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cntrl(req0_cntrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cntrl(req1_cntrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
        .resp_negative(resp_negative), .resp_zero(resp_zero), .resp_overflow(resp_overflow),
        .resp_carry_out(resp_carry_out), .resp_err(resp_err), .ops_done(ops_done)
    );

    alu_arbiter #(.EXEC_CYCLES(4), .CNT_W(32)) dut4 (
        .clk(clk), .reset_n(reset_n_4),
        .req0_valid(req0_valid_4), .req0_ready(req0_ready_4), .req0_a(req0_a_4), .req0_b(req0_b_4), .req0_cntrl(req0_cntrl_4),
        .req1_valid(req1_valid_4), .req1_ready(req1_ready_4), .req1_a(req1_a_4), .req1_b(req1_b_4), .req1_cntrl(req1_cntrl_4),
        .resp_valid(resp_valid_4), .resp_ready(resp_ready_4), .resp_id(resp_id_4), .resp_result(resp_result_4),
        .resp_negative(resp_negative_4), .resp_zero(resp_zero_4), .resp_overflow(resp_overflow_4),
        .resp_carry_out(resp_carry_out_4), .resp_err(resp_err_4), .ops_done(ops_done_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: results from plain mathematical definitions of each op
    function automatic exp_t ref_op(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                                    input logic id);
        exp_t e;
        logic signed [65:0] s;
        logic [64:0] w;
        e = '0;
        e.id = id;
        case (c)
            3'b000: e.result = b;
            3'b010: begin
                w = {1'b0, a} + {1'b0, b};
                e.result = w[63:0];
                e.c = w[64];
                s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                e.v = (s != $signed({{2{e.result[63]}}, e.result}));
            end
            3'b011: begin
                e.result = a - b;
                e.c = (a >= b);
                s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                e.v = (s != $signed({{2{e.result[63]}}, e.result}));
            end
            3'b100: e.result = a & b;
            3'b101: e.result = a | b;
            3'b110: e.result = a ^ b;
            default: e.err = 1'b1;
        endcase
        if (!e.err) begin
            e.n = e.result[63];
            e.z = (e.result == 64'd0);
        end
        return e;
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] r;
        case ($urandom_range(0, 5))
            0: r = 64'd0;
            1: r = '1;
            2: r = 64'h8000_0000_0000_0000;
            3: r = 64'h7FFF_FFFF_FFFF_FFFF;
            4: r = 64'($urandom_range(0, 15));
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // Monitor and reference model for arbitration, latency and responses
    always @(negedge clk) begin : mon
        bit   g, e0, e1, evalid;
        exp_t e;
        if (mon_en) begin
            g  = req1_valid && (!req0_valid || rr_m);
            e0 = !busy_m && req0_valid && !g;
            e1 = !busy_m && req1_valid && g;
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            evalid = busy_m && (cyc >= acc_cyc + E);
            chk("resp_valid", 64'(resp_valid), 64'(evalid));
            chk("ops_done", 64'(ops_done), 64'(done_m));
            if (resp_valid && evalid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got response expected none");
                end else begin
                    e = sb[0];
                    chk("resp_result", resp_result, e.result);
                    chk("resp_id_flags_err",
                        {58'd0, resp_id, resp_negative, resp_zero, resp_overflow, resp_carry_out, resp_err},
                        {58'd0, e.id, e.n, e.z, e.v, e.c, e.err});
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        done_m++;
                        busy_m = 0;
                    end
                end
            end
            if (e0 || e1) begin
                sb.push_back(g ? ref_op(req1_cntrl, req1_a, req1_b, 1'b1)
                               : ref_op(req0_cntrl, req0_a, req0_b, 1'b0));
                busy_m  = 1;
                acc_cyc = cyc + 1;
                rr_m    = !g;
            end
        end
    end

    task automatic drive(input bit id, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_cntrl = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cntrl = c; req0_a = a; req0_b = b;
        end
    endtask

    task automatic drop(input bit id);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input bit id, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        bit took;
        took = 0;
        drive(id, c, a, b);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                took = 1;
                break;
            end
        end
        if (!took) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req%0d ready got 0 expected 1", id);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && !busy_m) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
        end
        #1;
    endtask

    task automatic rand_stream(input bit id, input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                drop(id);
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(id, 3'($urandom_range(0, 7)), rand64(), rand64());
        end
        drop(id);
    endtask

    initial begin : main
        bit seen;
        int cnt;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cntrl = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cntrl = 0;
        resp_ready = 1;
        req0_valid_4 = 0; req0_a_4 = 0; req0_b_4 = 0; req0_cntrl_4 = 0;
        req1_valid_4 = 0; req1_a_4 = 0; req1_b_4 = 0; req1_cntrl_4 = 0;
        resp_ready_4 = 0;
        reset_n = 1; reset_n_4 = 1;
        #1 reset_n = 0; reset_n_4 = 0;
        drive(0, 3'b010, 64'd1, 64'd2);
        drive(1, 3'b010, 64'd3, 64'd4);

        @(negedge clk);
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(req1_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        chk("rst_id_flags_err", {58'd0, resp_id, resp_negative, resp_zero, resp_overflow, resp_carry_out, resp_err}, 64'd0);
        chk("rst_ops_done", 64'(ops_done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1; req0_valid = 0; req1_valid = 0; mon_en = 1;

        // Directed arithmetic corners
        issue(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); drop(0); drain();
        issue(1, 3'b011, 64'h8000_0000_0000_0000, 64'd1);
        issue(1, 3'b110, 64'h5555, 64'h5555); drop(1); drain();
        issue(0, 3'b111, 64'h1234, 64'h5678);
        issue(0, 3'b001, 64'hFFFF, 64'h1);
        issue(0, 3'b101, 64'hF0, 64'h0F); drop(0); drain();

        // Both requesters continuously valid: grants must alternate
        fork
            begin
                for (int k = 0; k < 3; k++) issue(0, 3'b010, 64'(k), 64'd10);
                drop(0);
            end
            begin
                for (int k = 0; k < 3; k++) issue(1, 3'b100, '1, 64'(k + 5));
                drop(1);
            end
        join
        drain();

        // Consumer stall with a second request pending
        resp_ready = 0;
        fork
            begin
                issue(0, 3'b011, 64'd5, 64'd9);
                issue(0, 3'b000, 64'd0, 64'hDEAD);
                drop(0);
            end
            begin
                seen = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (resp_valid) begin seen = 1; break; end
                end
                if (!seen) begin
                    checks++; errors++;
                    $display("FAIL stall_wait: resp_valid got 0 expected 1");
                end
                repeat (10) @(posedge clk);
                #1 resp_ready = 1;
            end
        join
        drain();

        // Randomized traffic with random back-pressure
        rand_done = 0;
        fork
            begin
                fork
                    rand_stream(0, 40);
                    rand_stream(1, 40);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                resp_ready = 1;
            end
        join
        drain();

        // EXEC_CYCLES=4 instance: reset in the middle of an operation
        @(posedge clk); #1;
        reset_n_4 = 1;
        req0_valid_4 = 1; req0_cntrl_4 = 3'b010; req0_a_4 = 64'd2; req0_b_4 = 64'd3;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready_4) begin seen = 1; break; end
        end
        chk("d4_first_accept", 64'(seen), 64'd1);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 reset_n_4 = 0; req1_valid_4 = 1; req1_cntrl_4 = 3'b011; req1_a_4 = 64'd10; req1_b_4 = 64'd4;
        @(negedge clk);
        chk("d4_rst_req0_ready", 64'(req0_ready_4), 64'd0);
        chk("d4_rst_req1_ready", 64'(req1_ready_4), 64'd0);
        chk("d4_rst_resp_valid", 64'(resp_valid_4), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n_4 = 1; req0_valid_4 = 0; req1_valid_4 = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid_4) seen = 1;
        end
        chk("d4_no_resp_after_rst", 64'(seen), 64'd0);
        chk("d4_ops_done_cleared", 64'(ops_done_4), 64'd0);
        @(posedge clk); #1;
        req0_valid_4 = 1; req1_valid_4 = 1;
        @(negedge clk);
        chk("d4_rr_reset_req0", 64'(req0_ready_4), 64'd1);
        chk("d4_rr_reset_req1", 64'(req1_ready_4), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) req0_valid_4 = 0;
            @(negedge clk);
            cnt++;
            if (resp_valid_4) break;
        end
        chk("d4_latency", 64'(cnt), 64'd5);
        chk("d4_result", resp_result_4, 64'd5);
        chk("d4_resp_id", 64'(resp_id_4), 64'd0);
        @(posedge clk); #1 resp_ready_4 = 1;
        @(posedge clk); #1 resp_ready_4 = 0;
        @(negedge clk);
        chk("d4_ops_done", 64'(ops_done_4), 64'd1);
        chk("d4_req1_next", 64'(req1_ready_4), 64'd1);
        @(posedge clk); #1 req1_valid_4 = 0;

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 64-bit alu instance between two requesters (e.g. execute-stage datapath and a multi-cycle address/branch unit). Round-robin arbitration; valid/ready handshake on both the request and response sides. Operands and flags are registered around the combinational alu, with a programmable settle time for its long ripple path. Sits between the issuing units and the alu.

Parameters:
EXEC_CYCLES, 1, cycles alu inputs are held stable before result/flags are captured (legal 1..15)
CNT_W, 32, width of the completed-operation counter

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&&ready
req0_a  in  64  operand A
req0_b  in  64  operand B
req0_cntrl  in  3  alu op: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
req1_valid, req1_ready, req1_a, req1_b, req1_cntrl  same as requester 0
resp_valid  out  1  response held
resp_ready  in  1  consumer takes response when valid&&ready
resp_id  out  1  requester that issued the op
resp_result  out  64  alu result
resp_negative, resp_zero, resp_overflow, resp_carry_out  out  1 each  captured flags
resp_err  out  1  op had illegal cntrl (001 or 111)
ops_done  out  CNT_W  count of completed handshakes on the response side

Behaviour:
- Reset (async, reset_n low): state IDLE, rr pointer=0, resp_valid=0, resp_id=0, resp_result=0, all flags 0, resp_err=0, ops_done=0, operand regs 0. reqN_ready=0 while reset asserted.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant = only valid requester; if both valid, the one selected by rr pointer. req_ready asserted combinationally to the granted requester only; never to both. On acceptance: latch a, b, cntrl and id into operand regs, load cycle counter with EXEC_CYCLES-1, go to EXEC, set rr pointer to the non-accepted id.
- EXEC: alu A/B/cntrl driven only from operand regs. Counter decrements each cycle; at 0, capture result and flags into resp regs, set resp_valid=1, go to RESP.
- Latency: accept on edge k -> resp_valid high after edge k+EXEC_CYCLES. Minimum issue interval EXEC_CYCLES+2 cycles with resp_ready tied high.
- RESP: all resp_* outputs stable while resp_valid && !resp_ready. On resp_ready: resp_valid=0, ops_done+1 (wraps 2^CNT_W-1 -> 0), go to IDLE. No request accepted in RESP.
- Flags: negative=result[63], zero=(result==0) for all legal ops; overflow and carry_out captured from alu for add/sub, forced 0 for pass/and/or/xor.
- Illegal cntrl: still accepted and sequenced; response has resp_err=1, result=0, zero=0, all other flags 0.
- Requester protocol: once valid is high, a, b, cntrl are held and valid is not dropped until accepted. Arbiter does not check this rule.
- reset_n asserted mid-EXEC or mid-RESP: operation discarded, no response produced, ops_done cleared.
- No combinational path from resp_ready to any reqN_ready.

Test Plan:
- Req0 add A=7FFFFFFFFFFFFFFF B=1, EXEC_CYCLES=1 -> after 1 cycle: resp_result=8000000000000000, overflow=1, negative=1, carry_out=0, zero=0, resp_id=0, ops_done=1.
- Req1 sub A=8000000000000000 B=1 -> result 7FFFFFFFFFFFFFFF, carry_out=1, overflow=1, negative=0; xor A=B=5555 -> zero=1, overflow=0, carry_out=0.
- Both valid continuously, 6 ops -> grants alternate 0,1,0,1,0,1; each req_ready is high only in IDLE, never both at once.
- resp_ready held low 10 cycles after resp_valid -> all resp_* outputs unchanged; req0_ready stays 0 and req0 stays pending; accepted in the first IDLE cycle after resp_ready.
- cntrl=111 from req0 -> resp_err=1, result=0, flags=0; next legal op -> resp_err=0.
- EXEC_CYCLES=4: reset_n pulsed low 2 cycles after acceptance -> resp_valid never rises, ops_done=0, state IDLE, rr pointer=0.
